// File: rtl/bus_resp85_pkg.sv
// -----------------------------------------------------------------------------
// bus_resp85_pkg
//   Shared definitions for the 8085 bus responder and its cycle controller:
//   IO/M_ status encodings, the one-hot responder state encoding, the wait
//   counter width, the data width, and the address-window compare helper.
// -----------------------------------------------------------------------------
package bus_resp85_pkg;

  // IO/M_ status as driven by the controller during T1.
  localparam logic IOM_MEM = 1'b0;
  localparam logic IOM_IO  = 1'b1;

  // Data bus width on the multiplexed AD lines.
  localparam int DATA_W = 8;

  // Wait counter width; covers WAIT_CNT 0..15.
  localparam int WCNT_W = 4;

  // One-hot responder states.
  //   ST_IDLE : not selected
  //   ST_ADDR : address latched and in window, counting wait states
  //   ST_XFER : strobe active, data phase
  //   ST_DONE : strobe released, one clock before returning to idle
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ADDR = 4'b0010,
    ST_XFER = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  // Window compare: only bits at and above 'bits' take part, so the low
  // 'bits' address bits index the window directly.
  function automatic logic window_hit(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input int          bits);
    return (addr >> bits) == (base >> bits);
  endfunction

endpackage

// File: rtl/resp85_ram.sv
// -----------------------------------------------------------------------------
// resp85_ram
//   Byte-wide register array backing the responder: synchronous write,
//   asynchronous read, 2**ADDR_BITS entries. Contents are not reset.
//
// Ports
//   clk_     in   clock; writes take effect on posedge
//   i_we     in   write enable for the current clock
//   i_addr   in   ADDR_BITS  shared read/write index
//   i_wdata  in   8          write data
//   o_rdata  out  8          combinational read of entry i_addr
// -----------------------------------------------------------------------------
module resp85_ram
  import bus_resp85_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk_,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/bus_resp85.sv
// -----------------------------------------------------------------------------
// bus_resp85
//   Memory or I/O slave on the 8085 multiplexed AD bus. Latches the address
//   on ALE, decodes a parameterised window and space, drives read data on AD
//   while RD_ is low, captures write data while WR_ is low and commits it
//   once WR_ rises, and holds READY low for WAIT_CNT clocks per selected
//   cycle.
//
// Parameters
//   BASE_ADDR  window base (bits at and above ADDR_BITS are compared)
//   ADDR_BITS  window size 2**ADDR_BITS bytes, 1..12
//   IS_IO      0: answer memory cycles, 1: answer I/O cycles
//   WAIT_CNT   wait states inserted per selected cycle, 0..15
//
// Ports
//   clk_   in     bus clock, all state changes on posedge
//   rst_   in     asynchronous reset, active high
//   ale    in     address latch enable
//   a_hi   in  8  A15..A8
//   ad     inout 8  A7..A0 during ALE, D7..D0 otherwise
//   iom_   in     IO/M_ status
//   rd_    in     read strobe, active low
//   wr_    in     write strobe, active low
//   ready  out    low requests a wait state (wired-AND at system level)
//   sel    out    this block owns the current bus cycle
//
// Bus handshake: after the latch edge the controller samples READY each
// clock; READY low means "hold the strobe, another TW follows". A strobe
// that is low while READY is high is accepted on that posedge, and the
// cycle ends on the first posedge that sees both strobes high again.
// -----------------------------------------------------------------------------
module bus_resp85
  import bus_resp85_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          ADDR_BITS = 8,
  parameter int          IS_IO     = 0,
  parameter int          WAIT_CNT  = 0
) (
  input  logic              clk_,
  input  logic              rst_,
  input  logic              ale,
  input  logic [7:0]        a_hi,
  inout  wire  [DATA_W-1:0] ad,
  input  logic              iom_,
  input  logic              rd_,
  input  logic              wr_,
  output logic              ready,
  output logic              sel
);

  localparam logic              L_IOM  = (IS_IO != 0) ? IOM_IO : IOM_MEM;
  localparam logic [WCNT_W-1:0] L_WAIT = WCNT_W'(WAIT_CNT);
  localparam logic [WCNT_W-1:0] L_ONE  = WCNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_e                r_state;
  state_e                w_state_nxt;
  logic [WCNT_W-1:0]     r_wcnt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [DATA_W-1:0]     r_wdat;
  logic                  r_wr_d;

  logic [15:0]           w_bus_addr;
  logic                  w_hit;
  logic                  w_wcnt_zero;
  logic                  w_sel;
  logic                  w_oe;
  logic                  w_commit;
  logic [DATA_W-1:0]     w_rdata;

  // Full 16-bit address as presented during the ALE clock.
  assign w_bus_addr  = {a_hi, ad};
  assign w_hit       = (iom_ == L_IOM) && window_hit(w_bus_addr, BASE_ADDR, ADDR_BITS);
  assign w_wcnt_zero = (r_wcnt == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ALE has priority in every state, so a new cycle can start directly out
  // of DONE and a cycle in progress is abandoned when ALE reappears.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (ale) begin
      w_state_nxt = w_hit ? ST_ADDR : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_ADDR: begin
          if (w_wcnt_zero && (!rd_ || !wr_)) begin
            w_state_nxt = ST_XFER;
          end
        end
        ST_XFER: begin
          if (rd_ && wr_) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // READY drops only while wait states remain, so it is already valid for
  // the controller's T2 sample right after the latch edge.
  // The read enable follows rd_ combinationally so AD is released as soon
  // as RD_ rises; a simultaneous WR_ suppresses the read drive.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel = 1'b0;
    ready = 1'b1;
    case (r_state)
      ST_ADDR: begin
        w_sel = 1'b1;
        ready = w_wcnt_zero;
      end
      ST_XFER: w_sel = 1'b1;
      ST_DONE: w_sel = 1'b1;
      default: w_sel = 1'b0;
    endcase
    w_oe = w_sel && w_wcnt_zero && !rd_ && wr_ && (r_state != ST_DONE);
  end

  assign sel = w_sel;

  // ---------------------------------------------------------------------------
  // Address latch, wait counter and write-data capture
  // r_wr_d holds the previous wr_ only while selected; it is forced high on
  // ALE and reset so an aborted or reset cycle never produces a commit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_ or posedge rst_) begin
    if (rst_) begin
      r_wcnt <= '0;
      r_addr <= '0;
      r_wdat <= '0;
      r_wr_d <= 1'b1;
    end else if (ale) begin
      r_addr <= w_bus_addr[ADDR_BITS-1:0];
      r_wcnt <= w_hit ? L_WAIT : '0;
      r_wr_d <= 1'b1;
    end else begin
      if ((r_state == ST_ADDR) && !w_wcnt_zero) begin
        r_wcnt <= r_wcnt - L_ONE;
      end
      if (w_sel && !wr_) begin
        r_wdat <= ad;
      end
      r_wr_d <= w_sel ? wr_ : 1'b1;
    end
  end

  // Exactly one commit per cycle: the first selected posedge that sees WR_
  // high after it was sampled low. A coincident ALE wins and discards it.
  assign w_commit = w_sel && !r_wr_d && wr_ && !ale;

  // ---------------------------------------------------------------------------
  // Storage and AD tristate
  // ---------------------------------------------------------------------------
  resp85_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_    (clk_),
    .i_we    (w_commit),
    .i_addr  (r_addr),
    .i_wdata (r_wdat),
    .o_rdata (w_rdata)
  );

  assign ad = w_oe ? w_rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_resp85.sv
// -----------------------------------------------------------------------------
// tb_bus_resp85
//   Three responders share one set of bus controls, each on its own AD net
//   with a pull-up so a released bus reads 8'hFF:
//     u0: memory, base 16'h2000, 256 bytes, no wait states
//     u1: memory, base 16'h2000,  32 bytes, 3 wait states
//     u2: I/O,    base 16'h4000, 256 ports, no wait states
//   The reference model is a byte map keyed by (responder, window offset);
//   hit/miss and wait-state counts come from the window arithmetic.
// -----------------------------------------------------------------------------
module tb_bus_resp85;

  // Clock / reset and bus drive
  logic       clk_   = 1'b0;
  logic       rst_   = 1'b1;
  logic       ale    = 1'b0;
  logic [7:0] a_hi   = 8'h00;
  logic       iom_   = 1'b0;
  logic       rd_    = 1'b1;
  logic       wr_    = 1'b1;
  logic [7:0] drv    = 8'h00;
  logic       drv_oe = 1'b0;

  wire  [7:0] ad0;
  wire  [7:0] ad1;
  wire  [7:0] ad2;

  assign ad0 = drv_oe ? drv : 8'hzz;
  assign ad1 = drv_oe ? drv : 8'hzz;
  assign ad2 = drv_oe ? drv : 8'hzz;

  for (genvar b = 0; b < 8; b++) begin : g_pu
    pullup (ad0[b]);
    pullup (ad1[b]);
    pullup (ad2[b]);
  end

  logic ready0, ready1, ready2;
  logic sel0, sel1, sel2;
  wire [2:0] rdy_v = {ready2, ready1, ready0};
  wire [2:0] sel_v = {sel2, sel1, sel0};

  always #5 clk_ = ~clk_;

  bus_resp85 #(.BASE_ADDR(16'h2000), .ADDR_BITS(8), .IS_IO(0), .WAIT_CNT(0)) u0 (
    .clk_(clk_), .rst_(rst_), .ale(ale), .a_hi(a_hi), .ad(ad0), .iom_(iom_),
    .rd_(rd_), .wr_(wr_), .ready(ready0), .sel(sel0));

  bus_resp85 #(.BASE_ADDR(16'h2000), .ADDR_BITS(5), .IS_IO(0), .WAIT_CNT(3)) u1 (
    .clk_(clk_), .rst_(rst_), .ale(ale), .a_hi(a_hi), .ad(ad1), .iom_(iom_),
    .rd_(rd_), .wr_(wr_), .ready(ready1), .sel(sel1));

  bus_resp85 #(.BASE_ADDR(16'h4000), .ADDR_BITS(8), .IS_IO(1), .WAIT_CNT(0)) u2 (
    .clk_(clk_), .rst_(rst_), .ale(ale), .a_hi(a_hi), .ad(ad2), .iom_(iom_),
    .rd_(rd_), .wr_(wr_), .ready(ready2), .sel(sel2));

  // Responder parameters as seen by the model
  localparam int P_BASE [3] = '{32'h2000, 32'h2000, 32'h4000};
  localparam int P_BITS [3] = '{8, 5, 8};
  localparam int P_IO   [3] = '{0, 0, 1};
  localparam int P_WAIT [3] = '{0, 3, 0};

  int         total = 0;
  int         bad   = 0;
  logic [7:0] mem_m [int];

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic bit hits(input int k, input logic [15:0] a, input logic io);
    int span;
    span = 1 << P_BITS[k];
    return (int'(io) == P_IO[k]) && ((int'(a) / span) == (P_BASE[k] / span));
  endfunction

  function automatic int key_of(input int k, input logic [15:0] a);
    return k * 65536 + (int'(a) % (1 << P_BITS[k]));
  endfunction

  function automatic logic [7:0] ad_of(input int k);
    case (k)
      0:       return ad0;
      1:       return ad1;
      default: return ad2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [15:0] cur_a  = 16'h0000;
  logic        cur_io = 1'b0;

  // T1: present address and status with ALE high; latched on the next posedge.
  task automatic addr_phase(input logic io, input logic [15:0] a);
    @(negedge clk_);
    ale    = 1'b1;
    a_hi   = a[15:8];
    drv    = a[7:0];
    drv_oe = 1'b1;
    iom_   = io;
    cur_a  = a;
    cur_io = io;
  endtask

  // T2..T3 (+TW): strobe, wait for READY, check, release; returns on the
  // release posedge so the next addr_phase lands ALE while responders are
  // in DONE.
  task automatic data_phase(input bit is_wr, input logic [7:0] wd);
    int lows [3];
    int n;
    @(negedge clk_);
    ale = 1'b0;
    if (is_wr) begin
      drv = wd; drv_oe = 1'b1; rd_ = 1'b1; wr_ = 1'b0;
    end else begin
      drv_oe = 1'b0; wr_ = 1'b1; rd_ = 1'b0;
    end
    #1;
    lows = '{0, 0, 0};
    n = 0;
    while ((rdy_v != 3'b111) && (n < 40)) begin
      for (int k = 0; k < 3; k++) if (!rdy_v[k]) lows[k]++;
      @(negedge clk_);
      #1;
      n++;
    end
    chk("ready_timeout", 16'(n < 40), 16'd1);
    for (int k = 0; k < 3; k++) begin
      bit h;
      h = hits(k, cur_a, cur_io);
      chk($sformatf("tw_count u%0d a=%h", k, cur_a), 16'(lows[k]), 16'(h ? P_WAIT[k] : 0));
      chk($sformatf("sel u%0d a=%h", k, cur_a), 16'(sel_v[k]), 16'(h));
      if (!is_wr) begin
        if (!h) chk($sformatf("rd_miss_z u%0d a=%h", k, cur_a), 16'(ad_of(k)), 16'h00FF);
        else if (mem_m.exists(key_of(k, cur_a)))
          chk($sformatf("rd_data u%0d a=%h", k, cur_a), 16'(ad_of(k)), 16'(mem_m[key_of(k, cur_a)]));
      end
    end
    @(negedge clk_);
    rd_ = 1'b1; wr_ = 1'b1; drv_oe = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("release_z u%0d a=%h", k, cur_a), 16'(ad_of(k)), 16'h00FF);
    if (is_wr)
      for (int k = 0; k < 3; k++)
        if (hits(k, cur_a, cur_io)) mem_m[key_of(k, cur_a)] = wd;
    @(posedge clk_);
  endtask

  task automatic bus_wr(input logic io, input logic [15:0] a, input logic [7:0] d);
    addr_phase(io, a);
    data_phase(1'b1, d);
  endtask

  task automatic bus_rd(input logic io, input logic [15:0] a);
    addr_phase(io, a);
    data_phase(1'b0, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] ra;
    logic        rio;
    bit          can_rd;

    // Reset state
    repeat (2) @(negedge clk_);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready u%0d", k), 16'(rdy_v[k]), 16'd1);
      chk($sformatf("rst_sel u%0d", k), 16'(sel_v[k]), 16'd0);
      chk($sformatf("rst_ad u%0d", k), 16'(ad_of(k)), 16'h00FF);
    end
    @(negedge clk_);
    rst_ = 1'b0;

    // Memory write then read, no waits on u0
    bus_wr(1'b0, 16'h2034, 8'hA5);
    bus_rd(1'b0, 16'h2034);

    // Three wait states on u1
    bus_wr(1'b0, 16'h2010, 8'h3C);
    bus_rd(1'b0, 16'h2010);

    // Window misses: wrong upper address, wrong space
    bus_wr(1'b0, 16'h3034, 8'h5F);
    bus_wr(1'b1, 16'h3434, 8'h6E);
    bus_rd(1'b0, 16'h2034);

    // I/O responder: OUT/IN, then memory read of the same address
    bus_wr(1'b1, 16'h4040, 8'h5A);
    bus_rd(1'b1, 16'h4040);
    bus_rd(1'b0, 16'h4040);

    // ALE during a write's address/strobe phase abandons it
    bus_wr(1'b0, 16'h2005, 8'h22);
    bus_wr(1'b0, 16'h2007, 8'h33);
    addr_phase(1'b0, 16'h2005);
    @(negedge clk_);
    ale = 1'b0; drv = 8'h77; wr_ = 1'b0;
    addr_phase(1'b0, 16'h2007);
    data_phase(1'b0, 8'h00);
    bus_rd(1'b0, 16'h2005);

    // Back-to-back on adjacent window edges
    bus_wr(1'b0, 16'h20FF, 8'h81);
    bus_rd(1'b0, 16'h20FF);
    bus_wr(1'b0, 16'h2000, 8'hC3);
    bus_rd(1'b0, 16'h2000);
    bus_rd(1'b0, 16'h20FF);

    // Reset in the middle of a write data phase
    bus_wr(1'b0, 16'h2050, 8'h11);
    addr_phase(1'b0, 16'h2050);
    @(negedge clk_);
    ale = 1'b0; drv = 8'h99; wr_ = 1'b0;
    @(negedge clk_);
    drv_oe = 1'b0;
    rst_   = 1'b1;
    #1;
    chk("midrst_sel", 16'(sel0), 16'd0);
    chk("midrst_ready", 16'(ready0), 16'd1);
    chk("midrst_ad", 16'(ad0), 16'h00FF);
    @(negedge clk_);
    wr_ = 1'b1;
    @(negedge clk_);
    rst_ = 1'b0;
    bus_rd(1'b0, 16'h2050);

    // Randomised traffic across all windows plus misses
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       begin ra = 16'h2000 + 16'($urandom_range(0, 31));  rio = 1'b0; end
        1:       begin ra = 16'h2000 + 16'($urandom_range(0, 255)); rio = 1'b0; end
        2:       begin ra = {8'h40, 8'($urandom_range(0, 255))};    rio = 1'b1; end
        default: begin ra = 16'h5000 + 16'($urandom_range(0, 255)); rio = 1'($urandom_range(0, 1)); end
      endcase
      can_rd = 1'b1;
      for (int k = 0; k < 3; k++)
        if (hits(k, ra, rio) && !mem_m.exists(key_of(k, ra))) can_rd = 1'b0;
      if (can_rd && ($urandom_range(0, 1) == 1)) bus_rd(rio, ra);
      else bus_wr(rio, ra, 8'($urandom_range(0, 254)));
      repeat ($urandom_range(0, 2)) @(negedge clk_);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
